core_ctrl_fsm: RTL and testbench

//  Multi-cycle control sequencer for the FRiscV core. Fetches each instruction over an

---
 rtl/core_ctrl_fsm.sv | 171 +++++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl_fsm.sv
// rtl/core_ctrl_fsm.sv - multi-cycle fetch/decode/execute/mem/writeback sequencer for the FRiscV core
module core_ctrl_fsm #(
  parameter int              ARCH     = 32,
  parameter logic [ARCH-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_out,
  output logic [ARCH-1:0] imem_addr_out,
  input  logic            imem_gnt_in,
  input  logic [ARCH-1:0] imem_rdata_in,
  output logic [ARCH-1:0] instr_out,
  input  logic [6:0]      op_code_in,
  input  logic [2:0]      func3_in,
  input  logic            branch_taken_in,
  input  logic [ARCH-1:0] target_in,
  output logic            dmem_req_out,
  output logic            dmem_we_out,
  input  logic            dmem_gnt_in,
  output logic            rf_we_out,
  output logic [ARCH-1:0] pc_out,
  output logic            retire_out,
  output logic            illegal_instr_out,
  output logic [2:0]      state_out
);

  localparam logic [6:0] OP_REG       = 7'b0110011;
  localparam logic [6:0] OP_IMM_ARITH = 7'b0010011;
  localparam logic [6:0] OP_IMM_JUMP  = 7'b1100111;
  localparam logic [6:0] OP_IMM_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_U_L_LOAD  = 7'b0110111;
  localparam logic [6:0] OP_JUMP      = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [ARCH-1:0] pc_q, pc_d;
  logic [ARCH-1:0] instr_q, instr_d;
  logic            illegal_q, illegal_d;
  logic            retire_q, retire_d;
  logic            taken_q, taken_d;
  logic [ARCH-1:1] target_q, target_d;

  logic            op_legal;
  logic            op_jump;
  logic            op_branch;
  logic            use_taken;
  logic [ARCH-1:1] use_target;
  logic            redirect;
  logic            unused_bits;

  // func3 is decoded downstream; target bit0 is always discarded
  assign unused_bits = ^{func3_in, target_in[0]};

  always_comb begin
    op_legal = 1'b0;
    case (op_code_in)
      OP_REG, OP_IMM_ARITH, OP_IMM_JUMP, OP_IMM_LOAD,
      OP_STORE, OP_BRANCH, OP_U_L_LOAD, OP_JUMP: op_legal = 1'b1;
      default:                                   op_legal = 1'b0;
    endcase
  end

  assign op_jump   = (op_code_in == OP_JUMP) || (op_code_in == OP_IMM_JUMP);
  assign op_branch = (op_code_in == OP_BRANCH);

  // A branch retires on the same edge it samples the ALU, so bypass the held copy
  assign use_taken  = (state_q == S_EXECUTE) ? branch_taken_in : taken_q;
  assign use_target = (state_q == S_EXECUTE) ? target_in[ARCH-1:1] : target_q;
  assign redirect   = op_jump || (op_branch && use_taken);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;
    retire_d  = 1'b0;
    taken_d   = taken_q;
    target_d  = target_q;
    case (state_q)
      S_FETCH: begin
        if (imem_gnt_in) begin
          instr_d = imem_rdata_in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!op_legal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        taken_d  = branch_taken_in;
        target_d = target_in[ARCH-1:1];
        if ((op_jump || (op_branch && branch_taken_in)) && target_in[1]) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else if (op_code_in == OP_IMM_LOAD || op_code_in == OP_STORE) begin
          state_d = S_MEM;
        end else if (op_branch) begin
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (dmem_gnt_in) begin
          if (op_code_in == OP_STORE) begin
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      default: state_d = S_HALT;
    endcase
    if (retire_d) begin
      pc_d = redirect ? {use_target, 1'b0} : pc_q + ARCH'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      illegal_q <= 1'b0;
      retire_q  <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
      retire_q  <= retire_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
    end
  end

  assign imem_req_out      = (state_q == S_FETCH);
  assign imem_addr_out     = pc_q;
  assign dmem_req_out      = (state_q == S_MEM);
  assign dmem_we_out       = (state_q == S_MEM) && (op_code_in == OP_STORE);
  assign rf_we_out         = (state_q == S_WRITEBACK);
  assign instr_out         = instr_q;
  assign pc_out            = pc_q;
  assign retire_out        = retire_q;
  assign illegal_instr_out = illegal_q;
  assign state_out         = state_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb/tb_core_ctrl_fsm.sv - table-driven scoreboard bench for core_ctrl_fsm
module tb_core_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic [31:0] imem_rdata_in;
  logic [31:0] instr_out;
  logic [6:0]  op_code_in;
  logic [2:0]  func3_in;
  logic        branch_taken_in;
  logic [31:0] target_in;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic        dmem_gnt_in;
  logic        rf_we_out;
  logic [31:0] pc_out;
  logic        retire_out;
  logic        illegal_instr_out;
  logic [2:0]  state_out;

  core_ctrl_fsm #(.ARCH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_gnt_in(imem_gnt_in), .imem_rdata_in(imem_rdata_in),
    .instr_out(instr_out), .op_code_in(op_code_in), .func3_in(func3_in),
    .branch_taken_in(branch_taken_in), .target_in(target_in),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out), .dmem_gnt_in(dmem_gnt_in),
    .rf_we_out(rf_we_out), .pc_out(pc_out), .retire_out(retire_out),
    .illegal_instr_out(illegal_instr_out), .state_out(state_out)
  );

  // stand-in for instr_decode
  assign op_code_in = instr_out[6:0];
  assign func3_in   = instr_out[14:12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        taken;
    logic [31:0] target;
    int          iwait;
    int          dwait;
    int          exp_cyc;
    logic [31:0] exp_pc;
    logic        exp_ill;
    int          exp_wb;
    logic        exp_we;
  } vec_t;

  vec_t        tbl [14];
  vec_t        exp_q [$];
  int          errs;
  int          checks;
  logic [31:0] cur_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   cyc, fw, mw, wb, we_bad, addr_bad;
    bit   done;
    exp_q.push_back(v);
    cyc = 0; fw = 0; mw = 0; wb = 0; we_bad = 0; addr_bad = 0; done = 0;
    imem_rdata_in   = v.instr;
    branch_taken_in = v.taken;
    target_in       = v.target;
    while (!done && cyc < 50) begin
      cyc++;
      imem_gnt_in = 1'b0;
      dmem_gnt_in = 1'b0;
      if (state_out == 3'd0) begin
        if (imem_addr_out !== cur_pc) addr_bad++;
        imem_gnt_in = (fw == v.iwait);
        fw++;
      end
      if (state_out == 3'd3) begin
        if (dmem_we_out !== v.exp_we) we_bad++;
        dmem_gnt_in = (mw == v.dwait);
        mw++;
      end
      if (rf_we_out) wb++;
      @(negedge clk);
      imem_gnt_in = 1'b0;
      dmem_gnt_in = 1'b0;
      if (retire_out || state_out == 3'd5) done = 1;
    end
    e = exp_q.pop_front();
    chk("completed", 32'(done), 32'd1);
    chk("latency", 32'(cyc), 32'(e.exp_cyc));
    chk("pc", pc_out, e.exp_pc);
    chk("illegal", 32'(illegal_instr_out), 32'(e.exp_ill));
    chk("rf_we_cycles", 32'(wb), 32'(e.exp_wb));
    chk("dmem_we_in_mem", 32'(we_bad), 32'd0);
    chk("imem_addr", 32'(addr_bad), 32'd0);
    cur_pc = e.exp_pc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur_pc = 32'h0;
  endtask

  initial begin
    errs = 0; checks = 0; cur_pc = 32'h0;
    rst = 1'b1; imem_gnt_in = 1'b0; dmem_gnt_in = 1'b0;
    imem_rdata_in = 32'h0; branch_taken_in = 1'b0; target_in = 32'h0;

    //         instr          tk    target        iw dw cyc  pc            ill wb we
    tbl[0]  = '{32'h00500093, 1'b0, 32'h0,        0, 0, 4,  32'h4,        0,  1, 0}; // ADDI
    tbl[1]  = '{32'h0000A103, 1'b0, 32'h0,        2, 3, 10, 32'h8,        0,  1, 0}; // LW
    tbl[2]  = '{32'h0020A223, 1'b0, 32'h0,        0, 1, 5,  32'hC,        0,  0, 1}; // SW
    tbl[3]  = '{32'h00000063, 1'b1, 32'h40,       0, 0, 3,  32'h40,       0,  0, 0}; // BEQ taken
    tbl[4]  = '{32'h00000063, 1'b0, 32'h80,       0, 0, 3,  32'h44,       0,  0, 0}; // BEQ not taken
    tbl[5]  = '{32'h0000006F, 1'b0, 32'h101,      0, 0, 4,  32'h100,      0,  1, 0}; // JAL
    tbl[6]  = '{32'h123450B7, 1'b0, 32'h0,        1, 0, 5,  32'h104,      0,  1, 0}; // LUI
    tbl[7]  = '{32'h002081B3, 1'b0, 32'h0,        0, 0, 4,  32'h108,      0,  1, 0}; // ADD
    tbl[8]  = '{32'h00008067, 1'b0, 32'h201,      0, 0, 4,  32'h200,      0,  1, 0}; // JALR
    tbl[9]  = '{32'h0000006F, 1'b0, 32'hFFFFFFFD, 0, 0, 4,  32'hFFFFFFFC, 0,  1, 0}; // JAL to top
    tbl[10] = '{32'h00500093, 1'b0, 32'h0,        0, 0, 4,  32'h0,        0,  1, 0}; // ADDI wraps
    tbl[11] = '{32'h0000006F, 1'b0, 32'h102,      0, 0, 3,  32'h0,        1,  0, 0}; // JAL misaligned
    tbl[12] = '{32'h0000007F, 1'b0, 32'h0,        0, 0, 2,  32'h0,        1,  0, 0}; // bad opcode
    tbl[13] = '{32'h00500093, 1'b0, 32'h0,        0, 0, 4,  32'h4,        0,  1, 0}; // ADDI

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_imem_req", 32'(imem_req_out), 32'd1);
    chk("rst_dmem_req", 32'(dmem_req_out), 32'd0);
    chk("rst_rf_we", 32'(rf_we_out), 32'd0);
    chk("rst_retire", 32'(retire_out), 32'd0);
    chk("rst_illegal", 32'(illegal_instr_out), 32'd0);
    chk("rst_instr", instr_out, 32'h0);

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // HALT absorbs spurious grants
    chk("halt_state", 32'(state_out), 32'd5);
    imem_gnt_in = 1'b1;
    dmem_gnt_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("halt_hold", 32'(state_out), 32'd5);
    chk("halt_pc", pc_out, 32'h0);
    chk("halt_imem_req", 32'(imem_req_out), 32'd0);
    chk("halt_dmem_req", 32'(dmem_req_out), 32'd0);
    chk("halt_rf_we", 32'(rf_we_out), 32'd0);
    chk("halt_retire", 32'(retire_out), 32'd0);
    imem_gnt_in = 1'b0;
    dmem_gnt_in = 1'b0;
    do_reset();
    chk("rst_clears_illegal", 32'(illegal_instr_out), 32'd0);
    chk("rst_exits_halt", 32'(state_out), 32'd0);

    run_vec(tbl[12]);
    chk("badop_halt", 32'(state_out), 32'd5);
    do_reset();
    run_vec(tbl[13]);

    // retire pulse lasts one cycle, then reset during a MEM wait
    imem_rdata_in = 32'h0000A103;
    @(negedge clk);
    chk("retire_single_cycle", 32'(retire_out), 32'd0);
    chk("fetch_waits", 32'(state_out), 32'd0);
    for (int k = 0; k < 20 && state_out != 3'd3; k++) begin
      imem_gnt_in = (state_out == 3'd0);
      @(negedge clk);
      imem_gnt_in = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("mem_wait_req", 32'(dmem_req_out), 32'd1);
    chk("mem_wait_we", 32'(dmem_we_out), 32'd0);
    chk("mem_wait_pc", pc_out, 32'h4);
    do_reset();
    chk("mem_rst_dmem_req", 32'(dmem_req_out), 32'd0);
    chk("mem_rst_state", 32'(state_out), 32'd0);
    chk("mem_rst_pc", pc_out, 32'h0);
    chk("mem_rst_retire", 32'(retire_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
